// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU with one transaction in flight.
// Round-robin grant, per-op latency counting, and a divide/modulus-by-zero bypass.
module alu_arbiter #(
  parameter int N        = 8,
  parameter int SLOW_LAT = 3,
  parameter int FAST_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,

  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,

  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,

  output logic         busy,
  output logic         div0
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_MOD   = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b1000;
  localparam logic [3:0] SLOW_CNT = 4'(SLOW_LAT - 1);
  localparam logic [3:0] FAST_CNT = 4'(FAST_LAT - 1);

  state_t       state;
  logic         ptr;
  logic         id;
  logic         dz;
  logic [3:0]   cnt;
  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic [3:0]   op;
  logic [N-1:0] res;
  logic [3:0]   flags;
  logic         div0_pulse;

  logic         grant0;
  logic         grant1;
  logic         idle;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic [3:0]   sel_op;
  logic         sel_slow;
  logic         sel_dz;
  logic [3:0]   sel_cnt;
  logic         rsp_done;

  // Pointer only breaks ties; a lone valid requester is always granted.
  assign grant0 = req0_valid & (~req1_valid | ~ptr);
  assign grant1 = req1_valid & (~req0_valid |  ptr);
  assign idle   = (state == IDLE);

  // Gating with rst_n keeps the readies low while reset is held.
  assign req0_ready = rst_n & idle & grant0;
  assign req1_ready = rst_n & idle & grant1;

  assign sel_a    = grant1 ? req1_a  : req0_a;
  assign sel_b    = grant1 ? req1_b  : req0_b;
  assign sel_op   = grant1 ? req1_op : req0_op;
  assign sel_slow = (sel_op == OP_MUL) | (sel_op == OP_MOD) | (sel_op == OP_DIV);
  assign sel_dz   = ((sel_op == OP_MOD) | (sel_op == OP_DIV)) & (sel_b == '0);
  assign sel_cnt  = sel_dz ? 4'd0 : (sel_slow ? SLOW_CNT : FAST_CNT);

  assign rsp_done = (~id & rsp0_ready) | (id & rsp1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      id         <= 1'b0;
      dz         <= 1'b0;
      cnt        <= 4'd0;
      opa        <= '0;
      opb        <= '0;
      op         <= 4'd0;
      res        <= '0;
      flags      <= 4'd0;
      div0_pulse <= 1'b0;
    end else begin
      div0_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            opa   <= sel_a;
            opb   <= sel_b;
            op    <= sel_op;
            id    <= grant1;
            dz    <= sel_dz;
            cnt   <= sel_cnt;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            // A zero divisor never trusts the ALU output.
            res        <= dz ? '1 : alu_result;
            flags      <= dz ? 4'd0 : alu_flags;
            div0_pulse <= dz;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            ptr   <= ~id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a      = opa;
  assign alu_b      = opb;
  assign alu_ctrl   = op;
  assign rsp_result = res;
  assign rsp_flags  = flags;
  assign rsp0_valid = (state == RESP) & ~id;
  assign rsp1_valid = (state == RESP) &  id;
  assign busy       = ~idle;
  assign div0       = div0_pulse;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small behavioural ALU answers the shared port,
// and each step checks the arbiter's outputs against hand-computed values.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl, alu_flags;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       busy, div0;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.N(8), .SLOW_LAT(3), .FAST_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .busy(busy), .div0(div0)
  );

  always #5 clk = ~clk;

  // Reference ALU; divide/modulus by zero answers 0 with zero flag set,
  // which the arbiter must discard.
  logic [8:0]  w;
  logic [15:0] prod;
  always_comb begin
    w    = 9'd0;
    prod = 16'd0;
    case (alu_ctrl)
      4'b0000: w = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: w = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0010: begin
        prod = alu_a * alu_b;
        w    = {|prod[15:8], prod[7:0]};
      end
      4'b0100: w = (alu_b == 8'd0) ? 9'd0 : {1'b0, alu_a % alu_b};
      4'b1000: w = (alu_b == 8'd0) ? 9'd0 : {1'b0, alu_a / alu_b};
      default: w = {1'b0, alu_a & alu_b};
    endcase
    alu_result = w[7:0];
    alu_flags  = {w[7], (w[7:0] == 8'd0), 1'b0, w[8]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 0; rst_n = 0;
    req0_valid = 1; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;

    // Reset state: everything low, even with a request pending.
    #12;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_div0", div0, 0);
    req0_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    tick();

    // Single add on requester 0.
    req0_a = 8'h05; req0_b = 8'h03; req0_op = 4'b0000; req0_valid = 1;
    #1;
    chk("add_ready0", req0_ready, 1);
    chk("add_ready1", req1_ready, 0);
    tick(); req0_valid = 0;
    chk("add_busy", busy, 1);
    chk("add_alu_a", alu_a, 8'h05);
    chk("add_rsp0_early", rsp0_valid, 0);
    tick();
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_result", rsp_result, 8'h08);
    chk("add_flags", rsp_flags, 4'b0000);
    chk("add_div0", div0, 0);
    $display("txn add req0 result=%0h flags=%0b", rsp_result, rsp_flags);
    tick();
    chk("add_idle", busy, 0);
    chk("add_rsp0_drop", rsp0_valid, 0);

    // Slow multiply on requester 1: three EXEC cycles with stable ALU inputs.
    req1_a = 8'h07; req1_b = 8'h03; req1_op = 4'b0010; req1_valid = 1;
    #1;
    chk("mul_ready1", req1_ready, 1);
    chk("mul_ready0", req0_ready, 0);
    tick(); req1_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_busy", busy, 1);
      chk("mul_rsp1_early", rsp1_valid, 0);
      chk("mul_alu_a", alu_a, 8'h07);
      chk("mul_alu_b", alu_b, 8'h03);
      chk("mul_alu_ctrl", alu_ctrl, 4'b0010);
      tick();
    end
    chk("mul_rsp1_valid", rsp1_valid, 1);
    chk("mul_rsp0_valid", rsp0_valid, 0);
    chk("mul_result", rsp_result, 8'h15);
    chk("mul_flags", rsp_flags, 4'b0000);
    chk("mul_alu_hold", alu_a, 8'h07);
    $display("txn mul req1 result=%0h flags=%0b", rsp_result, rsp_flags);
    tick();

    // Back-pressure on requester 0 while requester 1 waits.
    rsp0_ready = 0;
    req0_a = 8'h01; req0_b = 8'h02; req0_op = 4'b0001; req0_valid = 1;
    req1_a = 8'h09; req1_b = 8'h00; req1_op = 4'b1000; req1_valid = 1;
    #1;
    chk("bp_ready0", req0_ready, 1);
    chk("bp_ready1", req1_ready, 0);
    tick();
    chk("bp_exec_ready0", req0_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_result", rsp_result, 8'hFF);
      chk("bp_flags", rsp_flags, 4'b1001);
      chk("bp_stall_ready0", req0_ready, 0);
      chk("bp_stall_ready1", req1_ready, 0);
      tick();
    end
    req0_valid = 0; rsp0_ready = 1;
    #1;
    chk("bp_rsp0_still", rsp0_valid, 1);
    chk("bp_hs_ready1", req1_ready, 0);
    $display("txn sub req0 result=%0h flags=%0b", rsp_result, rsp_flags);
    tick();

    // Divide by zero on requester 1, granted once the handshake completed.
    chk("dz_ready1", req1_ready, 1);
    chk("dz_rsp0_drop", rsp0_valid, 0);
    tick(); req1_valid = 0;
    chk("dz_busy", busy, 1);
    chk("dz_alu_ctrl", alu_ctrl, 4'b1000);
    chk("dz_div0_early", div0, 0);
    tick();
    chk("dz_rsp1_valid", rsp1_valid, 1);
    chk("dz_result", rsp_result, 8'hFF);
    chk("dz_flags", rsp_flags, 4'b0000);
    chk("dz_div0", div0, 1);
    $display("txn div0 req1 result=%0h flags=%0b", rsp_result, rsp_flags);
    tick();
    chk("dz_div0_pulse", div0, 0);
    chk("dz_rsp1_drop", rsp1_valid, 0);

    // Contention right after reset: grants alternate starting at 0.
    rst_n = 0;
    tick(); rst_n = 1;
    tick();
    req0_a = 8'h01; req0_b = 8'h01; req0_op = 4'b0000; req0_valid = 1;
    req1_a = 8'h02; req1_b = 8'h02; req1_op = 4'b0000; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      logic e;
      e = (i % 2) == 1;
      #1;
      chk("con_ready0", req0_ready, !e);
      chk("con_ready1", req1_ready, e);
      tick();
      chk("con_alu_a", alu_a, e ? 8'h02 : 8'h01);
      tick();
      chk("con_rsp0", rsp0_valid, !e);
      chk("con_rsp1", rsp1_valid, e);
      chk("con_result", rsp_result, e ? 8'h04 : 8'h02);
      $display("txn contention grant=%0d result=%0h", e, rsp_result);
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    // Quick add leaves the pointer at 1 before the mid-EXEC reset.
    req0_a = 8'h05; req0_b = 8'h03; req0_op = 4'b0000; req0_valid = 1;
    #1;
    tick(); req0_valid = 0;
    tick();
    chk("q_result", rsp_result, 8'h08);
    tick();

    req1_a = 8'h07; req1_b = 8'h03; req1_op = 4'b0010; req1_valid = 1;
    #1;
    chk("rt_ready1", req1_ready, 1);
    tick(); req1_valid = 0;
    tick();
    rst_n = 0;
    #1;
    chk("rt_busy", busy, 0);
    chk("rt_alu_a", alu_a, 0);
    chk("rt_alu_b", alu_b, 0);
    chk("rt_alu_ctrl", alu_ctrl, 0);
    chk("rt_rsp1", rsp1_valid, 0);
    chk("rt_result", rsp_result, 0);
    tick(); tick(); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      chk("rt_no_rsp0", rsp0_valid, 0);
      chk("rt_no_rsp1", rsp1_valid, 0);
      chk("rt_idle", busy, 0);
      tick();
    end
    req0_a = 8'h05; req0_b = 8'h03; req0_op = 4'b0000; req0_valid = 1;
    req1_valid = 1;
    #1;
    chk("rt_grant0", req0_ready, 1);
    chk("rt_grant1", req1_ready, 0);
    tick(); req0_valid = 0;
    tick();
    chk("rt_rsp0", rsp0_valid, 1);
    chk("rt_res", rsp_result, 8'h08);
    $display("txn post-reset req0 result=%0h", rsp_result);
    tick(); req1_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
